// File: rtl/fir_sched_pkg.sv
// rtl/fir_sched_pkg.sv - shared state encoding, defaults and sizing helper for the FIR stream scheduler
package fir_sched_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_MAX_TAPS       = 16;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LOADED,
        S_RUN,
        S_PUSH,
        S_COMPUTE,
        S_WAIT_Y,
        S_ERROR
    } sched_state_t;

    // Counter holds 0..cycles-1 before the timeout fires.
    function automatic int tmo_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// rtl/fir_sample_fifo.sv - sample FIFO with extra-bit pointer wrap, flush and same-cycle push/pop
module fir_sample_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fir_stream_scheduler.sv
// rtl/fir_stream_scheduler.sv - loads FIR coefficients, issues buffered samples and captures results
module fir_stream_scheduler
    import fir_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MAX_TAPS       = DEF_MAX_TAPS,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_start,
    input  logic [DATA_WIDTH-1:0] cfg_tap_count,
    input  logic                  coeff_valid,
    output logic                  coeff_ready,
    input  logic [DATA_WIDTH-1:0] coeff_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic                  busy,
    output logic                  loaded,
    output logic                  cfg_err,
    output logic                  timeout_err,
    output logic [DATA_WIDTH-1:0] dp_tap_count,
    output logic                  dp_coeff_valid,
    output logic [DATA_WIDTH-1:0] dp_coeff_data,
    input  logic                  dp_coeff_done,
    output logic                  dp_x_valid,
    output logic [DATA_WIDTH-1:0] dp_x_data,
    output logic                  dp_compute,
    input  logic                  dp_y_valid,
    input  logic [DATA_WIDTH-1:0] dp_y_data
);
    localparam int TW = tmo_width(TIMEOUT_CYCLES);

    sched_state_t          state;
    logic [DATA_WIDTH-1:0] coeff_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  tap_ok;
    logic                  y_free;
    logic                  tmo_hit;

    assign tap_ok    = (cfg_tap_count != '0) && (cfg_tap_count <= DATA_WIDTH'(MAX_TAPS));
    assign y_free    = !y_valid || y_ready;
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign coeff_ready = (state == S_LOAD);
    // Readiness follows the registered full flag, so a pop in the same cycle does not reopen it.
    assign x_ready     = loaded && !fifo_full && (state != S_ERROR);
    assign busy        = !((state == S_IDLE) || ((state == S_RUN) && fifo_empty));
    assign fifo_push   = x_valid && x_ready;
    assign fifo_pop    = (state == S_RUN) && !cfg_start && !fifo_empty && y_free;

    fir_sample_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (cfg_start),
        .push      (fifo_push),
        .push_data (x_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            coeff_cnt      <= '0;
            tmo_cnt        <= '0;
            loaded         <= 1'b0;
            cfg_err        <= 1'b0;
            timeout_err    <= 1'b0;
            dp_tap_count   <= '0;
            dp_coeff_valid <= 1'b0;
            dp_coeff_data  <= '0;
            dp_x_valid     <= 1'b0;
            dp_x_data      <= '0;
            dp_compute     <= 1'b0;
            y_valid        <= 1'b0;
            y_data         <= '0;
        end else begin
            dp_coeff_valid <= 1'b0;
            dp_x_valid     <= 1'b0;
            dp_compute     <= 1'b0;
            if (y_valid && y_ready)
                y_valid <= 1'b0;

            if (cfg_start) begin
                y_valid   <= 1'b0;
                loaded    <= 1'b0;
                coeff_cnt <= '0;
                tmo_cnt   <= '0;
                if (tap_ok) begin
                    dp_tap_count <= cfg_tap_count;
                    cfg_err      <= 1'b0;
                    timeout_err  <= 1'b0;
                    state        <= S_LOAD;
                end else begin
                    cfg_err <= 1'b1;
                    state   <= S_IDLE;
                end
            end else begin
                case (state)
                    S_LOAD: begin
                        if (coeff_valid) begin
                            dp_coeff_valid <= 1'b1;
                            dp_coeff_data  <= coeff_data;
                            coeff_cnt      <= coeff_cnt + 1'b1;
                            if (coeff_cnt + 1'b1 == dp_tap_count) begin
                                tmo_cnt <= '0;
                                state   <= S_WAIT_LOADED;
                            end
                        end
                    end
                    S_WAIT_LOADED: begin
                        if (dp_coeff_done) begin
                            loaded <= 1'b1;
                            state  <= S_RUN;
                        end else if (tmo_hit) begin
                            timeout_err <= 1'b1;
                            state       <= S_ERROR;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (fifo_pop) begin
                            dp_x_valid <= 1'b1;
                            dp_x_data  <= fifo_head;
                            state      <= S_PUSH;
                        end
                    end
                    S_PUSH: begin
                        dp_compute <= 1'b1;
                        state      <= S_COMPUTE;
                    end
                    S_COMPUTE: begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT_Y;
                    end
                    S_WAIT_Y: begin
                        if (dp_y_valid) begin
                            y_data  <= dp_y_data;
                            y_valid <= 1'b1;
                            state   <= S_RUN;
                        end else if (tmo_hit) begin
                            timeout_err <= 1'b1;
                            state       <= S_ERROR;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_stream_scheduler.sv
// tb/tb_fir_stream_scheduler.sv - directed bench for fir_stream_scheduler with a small datapath model
module tb_fir_stream_scheduler;

    logic        clk;
    logic        rstn;
    logic        cfg_start;
    logic [31:0] cfg_tap_count;
    logic        coeff_valid;
    logic        coeff_ready;
    logic [31:0] coeff_data;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] x_data;
    logic        y_valid;
    logic        y_ready;
    logic [31:0] y_data;
    logic        busy;
    logic        loaded;
    logic        cfg_err;
    logic        timeout_err;
    logic [31:0] dp_tap_count;
    logic        dp_coeff_valid;
    logic [31:0] dp_coeff_data;
    logic        dp_coeff_done;
    logic        dp_x_valid;
    logic [31:0] dp_x_data;
    logic        dp_compute;
    logic        dp_y_valid;
    logic [31:0] dp_y_data;

    fir_stream_scheduler #(
        .DATA_WIDTH     (32),
        .MAX_TAPS       (16),
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_start      (cfg_start),
        .cfg_tap_count  (cfg_tap_count),
        .coeff_valid    (coeff_valid),
        .coeff_ready    (coeff_ready),
        .coeff_data     (coeff_data),
        .x_valid        (x_valid),
        .x_ready        (x_ready),
        .x_data         (x_data),
        .y_valid        (y_valid),
        .y_ready        (y_ready),
        .y_data         (y_data),
        .busy           (busy),
        .loaded         (loaded),
        .cfg_err        (cfg_err),
        .timeout_err    (timeout_err),
        .dp_tap_count   (dp_tap_count),
        .dp_coeff_valid (dp_coeff_valid),
        .dp_coeff_data  (dp_coeff_data),
        .dp_coeff_done  (dp_coeff_done),
        .dp_x_valid     (dp_x_valid),
        .dp_x_data      (dp_x_data),
        .dp_compute     (dp_compute),
        .dp_y_valid     (dp_y_valid),
        .dp_y_data      (dp_y_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Posedge monitor: sole writer of these logs.
    logic [31:0] coeff_q[$];
    logic [31:0] dpx_q[$];
    logic [31:0] y_q[$];
    int          xacc_cyc_q[$];
    int          dpx_cyc_q[$];
    int          pcyc        = 0;
    int          n_compute   = 0;
    int          seq_err     = 0;
    int          compute_cyc = 0;
    int          tmo_cyc     = -1;
    logic        prev_xv     = 1'b0;
    logic        prev_to     = 1'b0;

    always @(posedge clk) begin
        pcyc++;
        if (rstn) begin
            if (dp_coeff_valid) coeff_q.push_back(dp_coeff_data);
            if (x_valid && x_ready) xacc_cyc_q.push_back(pcyc);
            if (dp_x_valid) begin
                dpx_q.push_back(dp_x_data);
                dpx_cyc_q.push_back(pcyc);
            end
            if (dp_compute) begin
                n_compute++;
                compute_cyc = pcyc;
            end
            if (prev_xv != dp_compute) seq_err++;
            prev_xv = dp_x_valid;
            if (y_valid && y_ready) y_q.push_back(y_data);
            if (timeout_err && !prev_to) tmo_cyc = pcyc;
            prev_to = timeout_err;
        end
    end

    // Datapath model state, driven only from the main process.
    int          n_coeff_seen = 0;
    int          done_target  = 0;
    int          done_cnt     = 0;
    int          y_cnt        = 0;
    logic        y_model_on   = 1'b1;
    logic [31:0] model_x      = '0;

    function automatic logic [31:0] exp_y(input logic [31:0] x);
        return x * 32'd3 + 32'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        dp_y_valid = 1'b0;
        if (dp_coeff_valid) begin
            n_coeff_seen++;
            if (n_coeff_seen == done_target) done_cnt = 3;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) dp_coeff_done = 1'b1;
        end
        if (dp_x_valid) model_x = dp_x_data;
        if (y_cnt > 0) begin
            y_cnt--;
            if (y_cnt == 0) begin
                dp_y_valid = 1'b1;
                dp_y_data  = exp_y(model_x);
            end
        end
        if (dp_compute && y_model_on) y_cnt = 2;
    endtask

    task automatic do_load(input int n, input logic [31:0] base);
        int   idx;
        int   bad;
        int   c0;
        int   xa0;
        logic hs;
        logic done_before;
        idx = 0;
        bad = 0;
        c0  = coeff_q.size();
        xa0 = xacc_cyc_q.size();
        n_coeff_seen  = 0;
        done_target   = n;
        done_cnt      = 0;
        dp_coeff_done = 1'b0;
        cfg_tap_count = n;
        cfg_start     = 1'b1;
        step();
        cfg_start = 1'b0;
        check("load_coeff_ready", coeff_ready, 1);
        check("load_loaded_low", loaded, 0);
        check("load_errs_clear", {cfg_err, timeout_err}, 0);
        x_valid     = 1'b1;
        x_data      = 32'hDEAD;
        coeff_valid = 1'b1;
        coeff_data  = base;
        for (int i = 0; i < 100 && !loaded; i++) begin
            hs          = coeff_valid && coeff_ready;
            done_before = dp_coeff_done;
            step();
            if (hs) begin
                idx++;
                coeff_data = base + idx;
                if (idx == n) coeff_valid = 1'b0;
            end
            if (loaded && !done_before) bad++;
        end
        x_valid     = 1'b0;
        coeff_valid = 1'b0;
        check("load_loaded", loaded, 1);
        check("load_done_before_loaded", bad, 0);
        check("load_pulse_count", coeff_q.size() - c0, n);
        for (int i = 0; i < n; i++)
            check($sformatf("load_coeff%0d", i),
                  (coeff_q.size() > c0 + i) ? coeff_q[c0 + i] : 32'hFFFF_FFFF, base + i);
        check("load_tap_count", dp_tap_count, n);
        check("load_no_early_sample", xacc_cyc_q.size() - xa0, 0);
    endtask

    task automatic push_samples(input int n, input logic [31:0] base, input logic [31:0] inc);
        int   idx;
        logic hs;
        idx     = 0;
        x_valid = 1'b1;
        x_data  = base;
        for (int i = 0; i < 300 && idx < n; i++) begin
            hs = x_valid && x_ready;
            step();
            if (hs) begin
                idx++;
                x_data = base + inc * idx;
                if (idx == n) x_valid = 1'b0;
            end
        end
        x_valid = 1'b0;
        check("push_all_accepted", idx, n);
    endtask

    typedef struct {
        logic [31:0] taps;
        logic        exp_err;
        logic        exp_load;
    } cfg_vec_t;

    cfg_vec_t tbl[5];

    initial begin
        int dx0;
        int xa0;
        int y0;
        int lat;
        int c0;

        tbl[0] = '{32'd0,         1'b1, 1'b0};
        tbl[1] = '{32'd17,        1'b1, 1'b0};
        tbl[2] = '{32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[3] = '{32'd16,        1'b0, 1'b1};
        tbl[4] = '{32'd1,         1'b0, 1'b1};

        rstn          = 1'b0;
        cfg_start     = 1'b0;
        cfg_tap_count = '0;
        coeff_valid   = 1'b0;
        coeff_data    = '0;
        x_valid       = 1'b0;
        x_data        = '0;
        y_ready       = 1'b1;
        dp_coeff_done = 1'b0;
        dp_y_valid    = 1'b0;
        dp_y_data     = '0;
        step();
        step();
        check("reset_flags", {busy, loaded, cfg_err, timeout_err, x_ready, coeff_ready, y_valid,
                              dp_coeff_valid, dp_x_valid, dp_compute}, 0);
        check("reset_data", y_data | dp_tap_count | dp_coeff_data | dp_x_data, 0);
        rstn = 1'b1;
        step();
        check("idle_after_reset", {busy, coeff_ready}, 0);

        // Tap-count legality; legal entries leave the block in LOAD, later ones abort it.
        c0 = coeff_q.size();
        for (int i = 0; i < 5; i++) begin
            cfg_tap_count = tbl[i].taps;
            cfg_start     = 1'b1;
            step();
            cfg_start = 1'b0;
            check($sformatf("cfg%0d_err", i), cfg_err, tbl[i].exp_err);
            check($sformatf("cfg%0d_coeff_ready", i), coeff_ready, tbl[i].exp_load);
            check($sformatf("cfg%0d_busy", i), busy, tbl[i].exp_load);
            if (tbl[i].exp_load)
                check($sformatf("cfg%0d_tap_count", i), dp_tap_count, tbl[i].taps);
            step();
        end
        check("cfg_no_coeff_pulses", coeff_q.size() - c0, 0);

        do_load(4, 32'd1);

        // Three back-to-back samples with results returned two cycles after compute.
        check("run_x_ready", x_ready, 1);
        dx0 = dpx_q.size();
        xa0 = xacc_cyc_q.size();
        y0  = y_q.size();
        c0  = n_compute;
        y_model_on = 1'b1;
        push_samples(3, 32'd10, 32'd10);
        for (int i = 0; i < 200 && (y_q.size() - y0) < 3; i++) step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dpx%0d", i), (dpx_q.size() > dx0 + i) ? dpx_q[dx0 + i] : 32'hFFFF_FFFF,
                  32'd10 * (i + 1));
            check($sformatf("y%0d", i), (y_q.size() > y0 + i) ? y_q[y0 + i] : 32'hFFFF_FFFF,
                  exp_y(32'd10 * (i + 1)));
        end
        check("compute_count", n_compute - c0, 3);
        check("compute_follows_x", seq_err, 0);
        check("x_to_dp_latency",
              (dpx_cyc_q.size() > dx0 && xacc_cyc_q.size() > xa0) ? dpx_cyc_q[dx0] - xacc_cyc_q[xa0] : -1, 2);

        // Backpressure: one result held, FIFO fills, then everything drains in order.
        y_ready = 1'b0;
        y0      = y_q.size();
        push_samples(9, 32'd101, 32'd1);
        for (int i = 0; i < 20; i++) step();
        check("bp_x_ready_low", x_ready, 0);
        check("bp_y_valid", y_valid, 1);
        check("bp_y_data", y_data, exp_y(32'd101));
        check("bp_busy", busy, 1);
        for (int i = 0; i < 5; i++) step();
        check("bp_y_stable", {31'd0, y_valid} | (y_data ^ exp_y(32'd101)), 1);
        y_ready = 1'b1;
        for (int i = 0; i < 400 && (y_q.size() - y0) < 9; i++) step();
        for (int i = 0; i < 9; i++)
            check($sformatf("bp_y%0d", i), (y_q.size() > y0 + i) ? y_q[y0 + i] : 32'hFFFF_FFFF,
                  exp_y(32'd101 + i));
        step();
        step();
        check("bp_drained", {busy, y_valid, x_ready}, 3'b001);

        // Datapath never answers: timeout, then cfg_start clears it and reloads.
        y_model_on = 1'b0;
        push_samples(1, 32'd7, 32'd0);
        for (int i = 0; i < 200 && !timeout_err; i++) step();
        check("tmo_err", timeout_err, 1);
        step();
        lat = tmo_cyc - compute_cyc;
        check("tmo_latency_in_range", (lat >= 64 && lat <= 66) ? 32'd1 : 32'd0, 1);
        check("tmo_outputs", {busy, x_ready, coeff_ready, dp_x_valid, dp_compute}, 5'b10000);
        do_load(4, 32'd5);

        // Asynchronous reset while waiting for a result.
        y_model_on = 1'b0;
        c0 = n_compute;
        push_samples(1, 32'd55, 32'd0);
        for (int i = 0; i < 50 && n_compute == c0; i++) step();
        step();
        step();
        check("pre_reset_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("async_reset_flags", {busy, loaded, cfg_err, timeout_err, x_ready, coeff_ready, y_valid,
                                    dp_coeff_valid, dp_x_valid, dp_compute}, 0);
        check("async_reset_data", y_data | dp_tap_count | dp_coeff_data | dp_x_data, 0);
        step();
        rstn = 1'b1;
        step();
        step();
        check("idle_after_release", {busy, coeff_ready, loaded, x_ready}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
